// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, queue entry layout,
// RV opcodes used by static prediction and immediate extraction helpers.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int XLEN    = 64;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
        logic               taken;
    } fetch_entry_t;

    // B-type immediate, sign-extended to XLEN
    function automatic logic [XLEN-1:0] imm_b(input logic [INSTR_W-1:0] i);
        return {{(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    // J-type immediate, sign-extended to XLEN
    function automatic logic [XLEN-1:0] imm_j(input logic [INSTR_W-1:0] i);
        return {{(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction FIFO with flush. Head/tail pointers wrap modulo DEPTH
// (DEPTH is a power of two, so natural pointer overflow is the wrap).
// Push and pop in the same cycle are allowed even when full.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output logic          head_valid,
    output fetch_entry_t  head_data,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  slots_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Pointer and occupancy next-state; flush empties the queue outright
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Pointer/count registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage write port
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count gates visibility, so stale slots are never read.
        if (push && !flush) slots_q[tail_q] <= push_data;
    end

    assign head_valid = (count_q != '0);
    assign head_data  = slots_q[head_q];
    assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end. One outstanding memory read at a time; returned
// words are queued and presented to decode over valid/ready.
// Optional static prediction enabled by defining FETCH_STATIC_PREDICT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [63:0] RESET_PC    = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instruction,
    output logic [63:0] pc,
    output logic        branch_taken
);

    localparam int            CW          = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C     = CW'(QUEUE_DEPTH);
    localparam logic [CW-1:0] LAST_SLOT_C = CW'(QUEUE_DEPTH - 1);

    fetch_state_t  state_q, state_d;
    logic [63:0]   fetch_pc_q, fetch_pc_d;

    logic          q_push, q_pop, q_flush, q_head_valid;
    fetch_entry_t  q_push_data, q_head_data;
    logic [CW-1:0] q_count;

    logic          pred_taken;
    logic [63:0]   next_pc;

    // Prediction of the word being returned, evaluated at push time
    always_comb begin
        pred_taken = 1'b0;
        next_pc    = fetch_pc_q + 64'd4;
`ifdef FETCH_STATIC_PREDICT_EN
        if (mem_resp_data[6:0] == OPC_JAL) begin
            pred_taken = 1'b1;
            next_pc    = fetch_pc_q + imm_j(mem_resp_data);
        end else if (mem_resp_data[6:0] == OPC_BRANCH && mem_resp_data[31]) begin
            pred_taken = 1'b1;
            next_pc    = fetch_pc_q + imm_b(mem_resp_data);
        end
`endif
    end

    // Fetch FSM next-state; redirect overrides everything else in the cycle
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        q_push     = 1'b0;
        q_flush    = 1'b0;
        if (redirect_valid) begin
            q_flush    = 1'b0 | 1'b1;
            fetch_pc_d = redirect_pc;
            unique case (state_q)
                // An outstanding read must still be swallowed, unless it lands this very cycle.
                ST_WAIT, ST_DISCARD: state_d = mem_resp_valid ? ST_IDLE : ST_DISCARD;
                default:             state_d = ST_IDLE;
            endcase
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (q_count < DEPTH_C) state_d = ST_REQ;
                end
                ST_REQ: begin
                    if (mem_req_ready) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        q_push     = 1'b1;
                        fetch_pc_d = next_pc;
                        // Skip IDLE when a slot is still free so a single-cycle memory
                        // sustains one instruction every two cycles.
                        state_d    = (q_count < LAST_SLOT_C || q_pop) ? ST_REQ : ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (mem_resp_valid) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state and fetch address registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // A redirect withdraws an unaccepted request in the same cycle
    assign mem_req_valid = (state_q == ST_REQ) && !redirect_valid;
    assign mem_req_addr  = fetch_pc_q;

    assign q_pop       = q_head_valid && out_ready && !redirect_valid;
    assign q_push_data = '{instr: mem_resp_data, pc: fetch_pc_q, taken: pred_taken};

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (q_flush),
        .push       (q_push),
        .push_data  (q_push_data),
        .pop        (q_pop),
        .head_valid (q_head_valid),
        .head_data  (q_head_data),
        .count      (q_count)
    );

    // Decode-side outputs are forced to zero whenever the head is not valid
    assign out_valid    = q_head_valid;
    assign instruction  = q_head_valid ? q_head_data.instr : 32'h0;
    assign pc           = q_head_valid ? q_head_data.pc    : 64'h0;
    assign branch_taken = q_head_valid && q_head_data.taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Drives inputs 2 time units after posedge,
// samples on negedge. A background responder models a single-cycle memory
// unless the test takes manual control of the response port.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [63:0] pc;
    logic        branch_taken;

    int checks = 0;
    int errors = 0;
    bit manual = 1'b0;

`ifdef FETCH_STATIC_PREDICT_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .QUEUE_DEPTH (4),
        .RESET_PC    (64'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instruction    (instruction),
        .pc             (pc),
        .branch_taken   (branch_taken)
    );

    function automatic logic [31:0] word_for(input logic [63:0] a);
        case (a)
            64'h20:  return 32'hFE000EE3;
            64'h40:  return 32'h0080006F;
            default: return 32'h00000013;
        endcase
    endfunction

    // Single-cycle memory: data returned in the cycle after the accepting edge
    initial begin : responder
        logic        acc;
        logic [63:0] a;
        forever begin
            @(negedge clk);
            acc = !manual && mem_req_valid && mem_req_ready;
            a   = mem_req_addr;
            @(posedge clk);
            #1;
            if (!manual) begin
                mem_resp_valid = acc;
                mem_resp_data  = acc ? word_for(a) : 32'h0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Next handshake on the decode side, bounded
    task automatic get_pop(output logic [63:0] p, output logic [31:0] ins,
                           output logic tk, output bit ok);
        ok = 1'b0; p = '0; ins = '0; tk = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            smp();
            if (out_valid && out_ready) begin
                p = pc; ins = instruction; tk = branch_taken; ok = 1'b1;
            end
            cyc();
        end
    endtask

    // Next accepted memory request, bounded; returns in the WAIT cycle
    task automatic wait_req(output bit ok, output logic [63:0] a);
        ok = 1'b0; a = '0;
        for (int k = 0; k < 10 && !ok; k++) begin
            smp();
            if (mem_req_valid && mem_req_ready) begin
                ok = 1'b1; a = mem_req_addr;
            end
            cyc();
        end
    endtask

    task automatic expect_pop(input string name, input logic [63:0] exp_pc,
                              input logic [31:0] exp_ins, input logic exp_tk);
        logic [63:0] p; logic [31:0] ins; logic tk; bit ok;
        get_pop(p, ins, tk, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got no pop within budget, required pc %h", name, exp_pc);
        end else if (p !== exp_pc || ins !== exp_ins || tk !== exp_tk) begin
            errors++;
            $display("FAIL %s: got pc %h instr %h taken %b, required pc %h instr %h taken %b",
                     name, p, ins, tk, exp_pc, exp_ins, exp_tk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_req_ready = 1'b1; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        repeat (3) cyc();
        smp();
        checks++;
        if (mem_req_valid !== 1'b0 || out_valid !== 1'b0 || pc !== 64'h0 ||
            instruction !== 32'h0 || branch_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got req %b ov %b pc %h ins %h bt %b, required all 0",
                     mem_req_valid, out_valid, pc, instruction, branch_taken);
        end
        cyc();
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            smp();
            checks++;
            if (out_valid !== (n == 3)) begin
                errors++;
                $display("FAIL reset_latency cycle %0d: got out_valid %b, required %b",
                         n, out_valid, (n == 3));
            end
            if (n == 1) begin
                checks++;
                if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h0) begin
                    errors++;
                    $display("FAIL first_req: got valid %b addr %h, required 1 %h",
                             mem_req_valid, mem_req_addr, 64'h0);
                end
            end
            cyc();
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        expect_pop("stream_pc0", 64'h0, 32'h13, 1'b0);
        expect_pop("stream_pc4", 64'h4, 32'h13, 1'b0);
        expect_pop("stream_pc8", 64'h8, 32'h13, 1'b0);
    endtask

    task automatic test_backpressure();
        int accepts;
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h200;
        cyc();
        redirect_valid = 1'b0;
        accepts = 0;
        for (int k = 0; k < 30; k++) begin
            smp();
            if (mem_req_valid && mem_req_ready) accepts++;
            cyc();
        end
        checks++;
        if (accepts !== 4) begin
            errors++;
            $display("FAIL fill_count: got %0d requests, required 4", accepts);
        end
        smp();
        checks++;
        if (mem_req_valid !== 1'b0 || out_valid !== 1'b1 || pc !== 64'h200) begin
            errors++;
            $display("FAIL full_idle: got req %b ov %b pc %h, required 0 1 %h",
                     mem_req_valid, out_valid, pc, 64'h200);
        end
        cyc();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        accepts = 0;
        for (int k = 0; k < 20; k++) begin
            smp();
            if (mem_req_valid && mem_req_ready) accepts++;
            cyc();
        end
        checks++;
        if (accepts !== 1) begin
            errors++;
            $display("FAIL refill_count: got %0d requests, required 1", accepts);
        end
        smp();
        checks++;
        if (out_valid !== 1'b1 || pc !== 64'h204 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_pop_head: got ov %b pc %h req %b, required 1 %h 0",
                     out_valid, pc, mem_req_valid, 64'h204);
        end
        cyc();
    endtask

    task automatic test_redirect_wait();
        bit ok; logic [63:0] a;
        out_ready = 1'b0; mem_req_ready = 1'b0;
        cyc(); cyc();
        manual = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
        redirect_valid = 1'b1; redirect_pc = 64'h300;
        cyc();
        redirect_valid = 1'b0; mem_req_ready = 1'b1;
        wait_req(ok, a);
        checks++;
        if (!ok || a !== 64'h300) begin
            errors++;
            $display("FAIL redir_req300: got ok %b addr %h, required 1 %h", ok, a, 64'h300);
        end
        mem_resp_valid = 1'b1; mem_resp_data = 32'h13;
        cyc();
        mem_resp_valid = 1'b0;
        wait_req(ok, a);
        checks++;
        if (!ok || a !== 64'h304) begin
            errors++;
            $display("FAIL redir_req304: got ok %b addr %h, required 1 %h", ok, a, 64'h304);
        end
        // now in WAIT with one entry queued
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        smp();
        checks++;
        if (out_valid !== 1'b1 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL pre_flush: got ov %b req %b, required 1 0", out_valid, mem_req_valid);
        end
        cyc();
        redirect_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h00000093;
        smp();
        checks++;
        if (out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_discard: got ov %b req %b, required 0 0", out_valid, mem_req_valid);
        end
        cyc();
        mem_resp_valid = 1'b0;
        wait_req(ok, a);
        checks++;
        if (!ok || a !== 64'h100) begin
            errors++;
            $display("FAIL redir_target: got ok %b addr %h, required 1 %h", ok, a, 64'h100);
        end
        mem_resp_valid = 1'b1; mem_resp_data = 32'h13;
        cyc();
        mem_resp_valid = 1'b0;
        manual = 1'b0;
        smp();
        checks++;
        if (out_valid !== 1'b1 || pc !== 64'h100 || instruction !== 32'h13) begin
            errors++;
            $display("FAIL redir_head: got ov %b pc %h ins %h, required 1 %h %h",
                     out_valid, pc, instruction, 64'h100, 32'h13);
        end
        cyc();
    endtask

    task automatic test_stall();
        logic [63:0] a0;
        out_ready = 1'b1;
        mem_req_ready = 1'b0;
        cyc(); cyc(); cyc();
        smp();
        a0 = mem_req_addr;
        checks++;
        if (mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_valid0: got %b, required 1", mem_req_valid);
        end
        for (int k = 1; k < 5; k++) begin
            cyc();
            smp();
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== a0) begin
                errors++;
                $display("FAIL stall_hold%0d: got valid %b addr %h, required 1 %h",
                         k, mem_req_valid, mem_req_addr, a0);
            end
        end
        cyc();
        mem_req_ready = 1'b1;
        expect_pop("stall_release", a0, 32'h13, 1'b0);
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        expect_pop("wrap_last", 64'hFFFF_FFFF_FFFF_FFFC, 32'h13, 1'b0);
        expect_pop("wrap_zero", 64'h0, 32'h13, 1'b0);
    endtask

    task automatic test_predict();
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 64'h20;
        cyc();
        redirect_valid = 1'b0;
        expect_pop("beq_head", 64'h20, 32'hFE000EE3, PRED_EN);
        expect_pop("beq_next", PRED_EN ? 64'h1C : 64'h24, 32'h13, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 64'h40;
        cyc();
        redirect_valid = 1'b0;
        expect_pop("jal_head", 64'h40, 32'h0080006F, PRED_EN);
        expect_pop("jal_next", PRED_EN ? 64'h48 : 64'h44, 32'h13, 1'b0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_stall();
        test_wrap();
        test_predict();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
